classical_room_bank: RTL
========================

CLASSICAL_ROOM_BANK -- requirements
Module: classical_room_bank

Interface
REQ-001 Parameter WIDTH, default 8: data and LFSR width; legal values 8, 16, 32 only; elaboration error otherwise.
REQ-002 Parameter SLOTS, default 4: number of read-once slots, 2..16; SLOT_W = max(1, clog2(SLOTS)) is derived.
REQ-003 Parameter ONE_TIME_INIT, default 0: 1 means each slot may be provisioned only once per reset.
REQ-004 Parameter LFSR_SEED, default WIDTH'hA5 zero-extended; must be nonzero.
REQ-005 Ports, in order:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- init  in  1  provisioning strobe.
- init_slot  in  SLOT_W  slot to provision.
- value_in  in  WIDTH  provisioning value.
- read  in  1  one-cycle read strobe.
- read_slot  in  SLOT_W  slot to read.
- kill  in  1  global zeroize request.
- value_out  out  WIDTH  registered read data or obfuscation.
- read_valid  out  1  value_out carries a genuine slot value this cycle.
- read_reject  out  1  the previous-cycle read was refused.
- pad_enable  out  1  physical IO OE.
- fuse_blow  out  SLOTS  per-slot one-cycle collapse pulse.
- collapsed  out  SLOTS  per-slot collapsed status.
- busy  out  1  scrub in progress.
- dead  out  1  bank permanently disabled until reset.

Function
REQ-006 A free-running WIDTH-bit maximal-length LFSR SHALL advance every cycle after reset and never reach zero.
REQ-007 Each slot SHALL hold a state of EMPTY, ARMED or COLLAPSED.
REQ-008 init in RUN to an EMPTY slot SHALL store value_in and set the slot to ARMED at the edge.
- A COLLAPSED slot SHALL likewise re-arm when ONE_TIME_INIT=0.
- With ONE_TIME_INIT=1 it SHALL ignore init and remain COLLAPSED.
- init to an ARMED slot SHALL overwrite the stored value.
REQ-009 read in RUN to an ARMED slot with read_slot < SLOTS SHALL, in the following cycle, assert read_valid=1, pad_enable=1 and fuse_blow[slot]=1, with value_out equal to the stored value; latency is 1 cycle.
REQ-010 At that same edge the slot SHALL become COLLAPSED and its storage SHALL be overwritten with the current LFSR value.
REQ-011 A read to an EMPTY or COLLAPSED slot, to read_slot >= SLOTS, or while not in RUN SHALL produce read_reject=1 in the following cycle.
- read_valid, pad_enable and fuse_blow SHALL stay 0.
REQ-012 Whenever read_valid=0, value_out SHALL carry the registered LFSR value and never stored data.
REQ-013 pad_enable SHALL equal read_valid and SHALL be 0 in SCRUB and DEAD.
REQ-014 For simultaneous init and read to the same slot, the read SHALL take effect on the old contents and the init SHALL be dropped.
- If the slot is not ARMED, the read is rejected and the init takes effect.
- For different slots, both SHALL take effect.
REQ-015 Bank FSM states are RUN, SCRUB and DEAD.
- kill in RUN SHALL move to SCRUB; a read or init in the same cycle SHALL be treated as not in RUN.
REQ-016 SCRUB SHALL sweep one slot per cycle, index 0..SLOTS-1, overwriting storage with the LFSR and setting the slot to COLLAPSED, with busy=1.
- After index SLOTS-1 the FSM SHALL enter DEAD; SCRUB lasts exactly SLOTS cycles.
REQ-017 DEAD SHALL be sticky until reset_n is asserted, with dead=1 and busy=0; init and kill SHALL be ignored and reads rejected.
REQ-018 collapsed[i] SHALL be 1 exactly when slot i is in COLLAPSED.

Reset
REQ-019 Assertion of reset_n=0 SHALL immediately set all slots EMPTY, zero all storage, load LFSR_SEED into the LFSR and enter RUN.
- value_out SHALL be 0 and every other output 0, including pad_enable.
REQ-020 Reset mid-SCRUB or mid-read SHALL abort the operation with no further output pulses.

Structure
REQ-021 The package classical_room_pkg SHALL hold the slot_state_t and bank_state_t enums, the LFSR tap-mask function per WIDTH, and the default seed constant.
REQ-022 A sub-module classical_lfsr SHALL be parametrised by WIDTH and SEED and SHALL use the same reset_n.

Verification
REQ-023 init slot 2 = 0x3C, read slot 2 -> next cycle read_valid=1, value_out=0x3C, fuse_blow=4'b0100, collapsed[2]=1.
REQ-024 Second read of slot 2 -> read_reject=1, read_valid=0, pad_enable=0, value_out != 0x3C.
REQ-025 ONE_TIME_INIT=1: init slot 0 = 0x11, read, init slot 0 = 0x22, read -> second read rejected.
REQ-026 Simultaneous init slot 1 = 0x55 and read slot 1 holding 0xAA -> value_out=0xAA, slot 1 COLLAPSED, 0x55 dropped.
REQ-027 SLOTS=4, kill with all slots ARMED -> busy=1 for 4 cycles, then dead=1 and collapsed=4'b1111; any later read -> read_reject=1.
REQ-028 reset_n pulsed low during SCRUB -> all outputs 0 immediately, state RUN, and a fresh init/read succeeds.

Source files
------------

// File: rtl/classical_room_pkg.sv
// Shared types and constants for the read-once slot bank and its LFSR.
package classical_room_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY     = 2'd0,
    SLOT_ARMED     = 2'd1,
    SLOT_COLLAPSED = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    BANK_RUN   = 2'd0,
    BANK_SCRUB = 2'd1,
    BANK_DEAD  = 2'd2
  } bank_state_t;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_00A5;

  // Galois right-shift masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/classical_lfsr.sv
// Free-running maximal-length Galois LFSR; a nonzero seed keeps it off the all-zero state.
module classical_lfsr
  import classical_room_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] o_value
);

  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/classical_room_bank.sv
// Bank of read-once slots: a provisioned value is released once, then the slot collapses.
//   state | meaning
//   RUN   | normal provisioning and reads
//   SCRUB | zeroizing one slot per cycle after kill
//   DEAD  | all slots collapsed, everything refused until reset
module classical_room_bank
  import classical_room_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SLOTS         = 4,
  parameter bit               ONE_TIME_INIT = 1'b0,
  parameter logic [WIDTH-1:0] LFSR_SEED     = DEFAULT_SEED[WIDTH-1:0],
  localparam int              SLOT_W        = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [SLOT_W-1:0] init_slot,
  input  logic [WIDTH-1:0]  value_in,
  input  logic              read,
  input  logic [SLOT_W-1:0] read_slot,
  input  logic              kill,
  output logic [WIDTH-1:0]  value_out,
  output logic              read_valid,
  output logic              read_reject,
  output logic              pad_enable,
  output logic [SLOTS-1:0]  fuse_blow,
  output logic [SLOTS-1:0]  collapsed,
  output logic              busy,
  output logic              dead
);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("classical_room_bank: WIDTH must be 8, 16 or 32");
  end
  if (SLOTS < 2 || SLOTS > 16) begin : g_bad_slots
    $error("classical_room_bank: SLOTS must be in 2..16");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("classical_room_bank: LFSR_SEED must be nonzero");
  end

  localparam logic [SLOT_W:0]   SLOTS_X  = (SLOT_W + 1)'(SLOTS);
  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(SLOTS - 1);

  logic [WIDTH-1:0]  w_lfsr;
  logic [WIDTH-1:0]  r_data [SLOTS];
  slot_state_t       r_state [SLOTS];
  bank_state_t       r_bank;
  logic [SLOT_W-1:0] r_scrub_idx;
  logic [WIDTH-1:0]  r_value;
  logic              r_valid;
  logic              r_reject;
  logic [SLOTS-1:0]  r_fuse;

  logic w_run;
  logic w_rd_hit;
  logic w_init_ok;

  classical_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .o_value (w_lfsr)
  );

  // A kill in the same cycle pre-empts any read or init.
  assign w_run    = (r_bank == BANK_RUN) && !kill;
  assign w_rd_hit = read && w_run && ({1'b0, read_slot} < SLOTS_X)
                    && (r_state[read_slot] == SLOT_ARMED);
  // A colliding successful read wins; the init to that slot is dropped.
  assign w_init_ok = init && w_run && ({1'b0, init_slot} < SLOTS_X)
                     && !(w_rd_hit && (init_slot == read_slot))
                     && (!ONE_TIME_INIT || (r_state[init_slot] != SLOT_COLLAPSED));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank      <= BANK_RUN;
      r_scrub_idx <= '0;
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_reject    <= 1'b0;
      r_fuse      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_data[i]  <= '0;
        r_state[i] <= SLOT_EMPTY;
      end
    end else begin
      r_value  <= w_lfsr;
      r_valid  <= 1'b0;
      r_reject <= 1'b0;
      r_fuse   <= '0;
      case (r_bank)
        BANK_RUN: begin
          if (kill) begin
            r_bank      <= BANK_SCRUB;
            r_scrub_idx <= '0;
            r_reject    <= read;
          end else begin
            if (w_init_ok) begin
              r_data[init_slot]  <= value_in;
              r_state[init_slot] <= SLOT_ARMED;
            end
            if (w_rd_hit) begin
              r_valid            <= 1'b1;
              r_value            <= r_data[read_slot];
              r_fuse[read_slot]  <= 1'b1;
              r_data[read_slot]  <= w_lfsr;
              r_state[read_slot] <= SLOT_COLLAPSED;
            end else begin
              r_reject <= read;
            end
          end
        end
        BANK_SCRUB: begin
          r_data[r_scrub_idx]  <= w_lfsr;
          r_state[r_scrub_idx] <= SLOT_COLLAPSED;
          r_reject             <= read;
          if (r_scrub_idx == LAST_IDX) begin
            r_bank <= BANK_DEAD;
          end else begin
            r_scrub_idx <= r_scrub_idx + SLOT_W'(1);
          end
        end
        default: begin
          r_reject <= read;
        end
      endcase
    end
  end

  always_comb begin
    collapsed = '0;
    for (int i = 0; i < SLOTS; i++) begin
      collapsed[i] = (r_state[i] == SLOT_COLLAPSED);
    end
  end

  assign value_out   = r_value;
  assign read_valid  = r_valid;
  assign read_reject = r_reject;
  assign pad_enable  = r_valid;
  assign fuse_blow   = r_fuse;
  assign busy        = (r_bank == BANK_SCRUB);
  assign dead        = (r_bank == BANK_DEAD);

endmodule
